// File: rtl/pe_row_sequencer.sv
// Initiator-side sequencer for one row of processing elements.
// Launches a job into the chain, waits for its done pulse and returns the result.
module pe_row_sequencer #(
    parameter int NUM_PE         = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int OUTPUT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_PE*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PE*DATA_WIDTH-1:0] in_weight,
    input  logic [OUTPUT_WIDTH-1:0]      in_bias,
    output logic [NUM_PE*DATA_WIDTH-1:0] pe_data,
    output logic [NUM_PE*DATA_WIDTH-1:0] pe_weight,
    output logic [OUTPUT_WIDTH-1:0]      pe_partial_in,
    output logic                         pe_wr_en,
    output logic                         pe_start,
    input  logic                         chain_done,
    input  logic [OUTPUT_WIDTH-1:0]      chain_partial,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_WIDTH-1:0]      out_result,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESULT,
        ABORT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready      <= 1'b0;
            pe_data       <= '0;
            pe_weight     <= '0;
            pe_partial_in <= '0;
            pe_wr_en      <= 1'b0;
            pe_start      <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pe_data       <= in_data;
                        pe_weight     <= in_weight;
                        pe_partial_in <= in_bias;
                        timeout_err   <= 1'b0;
                        cnt           <= '0;
                        in_ready      <= 1'b0;
                        pe_wr_en      <= 1'b1;
                        pe_start      <= 1'b1;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    // a done pulse on the terminal-count cycle still counts as success
                    if (chain_done) begin
                        out_result <= chain_partial;
                        out_valid  <= 1'b1;
                        pe_wr_en   <= 1'b0;
                        pe_start   <= 1'b0;
                        state      <= RESULT;
                    end else if (cnt == TERM) begin
                        timeout_err <= 1'b1;
                        pe_wr_en    <= 1'b0;
                        pe_start    <= 1'b0;
                        state       <= ABORT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                ABORT: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    pe_wr_en <= 1'b0;
                    pe_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Bench for pe_row_sequencer: vector table, scoreboard and corner sequences.
// A behavioural MAC chain stands in for the PE row.
module tb_pe_row_sequencer;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int OW = 16;
    localparam int TO = 64;
    localparam int PW = 2 * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [NP*DW-1:0]  in_data;
    logic [NP*DW-1:0]  in_weight;
    logic [OW-1:0]     in_bias;
    logic [NP*DW-1:0]  pe_data;
    logic [NP*DW-1:0]  pe_weight;
    logic [OW-1:0]     pe_partial_in;
    logic              pe_wr_en;
    logic              pe_start;
    logic              chain_done;
    logic [OW-1:0]     chain_partial;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_result;
    logic              busy;
    logic              timeout_err;

    always #5 clk = ~clk;

    pe_row_sequencer #(
        .NUM_PE(NP), .DATA_WIDTH(DW),
        .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
        .pe_data(pe_data), .pe_weight(pe_weight),
        .pe_partial_in(pe_partial_in),
        .pe_wr_en(pe_wr_en), .pe_start(pe_start),
        .chain_done(chain_done), .chain_partial(chain_partial),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .busy(busy),
        .timeout_err(timeout_err)
    );

    // ideal chain: done_out pulses NUM_PE cycles after wr_en rises
    logic          chain_en;
    logic          man_done;
    logic          man_sel;
    logic [OW-1:0] man_partial;
    int unsigned   mcnt = 0;
    logic          model_done = 1'b0;

    function automatic logic [OW-1:0] mac(
        input logic [NP*DW-1:0] d,
        input logic [NP*DW-1:0] w,
        input logic [OW-1:0]    b
    );
        logic [OW-1:0] acc;
        logic [PW-1:0] p;
        acc = b;
        for (int i = 0; i < NP; i++) begin
            p = PW'(d[i*DW +: DW]) * PW'(w[i*DW +: DW]);
            acc = acc + p[OW-1:0];
        end
        return acc;
    endfunction

    always @(posedge clk) begin
        if (!pe_wr_en || !chain_en) begin
            mcnt       <= 0;
            model_done <= 1'b0;
        end else begin
            mcnt       <= mcnt + 1;
            model_done <= (mcnt == NP - 1);
        end
    end

    assign chain_done    = model_done | man_done;
    assign chain_partial = man_sel ? man_partial
                                   : mac(pe_data, pe_weight, pe_partial_in);

    int            n_vec = 0;
    int            n_bad = 0;
    logic [OW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious out_valid", out_valid, 0);
            else chk("scoreboard result", out_result, exp_q.pop_front());
        end
    end

    task automatic submit(input logic [NP*DW-1:0] d, input logic [NP*DW-1:0] w,
                          input logic [OW-1:0] b, input bit push,
                          input logic [OW-1:0] e);
        bit ok;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        in_bias   = b;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept timeout", in_ready, 1);
        else if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int wr);
        lat = 0;
        wr  = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (pe_wr_en) wr++;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) chk("out_valid timeout", out_valid, 1);
    endtask

    typedef struct {
        logic [NP*DW-1:0] data;
        logic [NP*DW-1:0] weight;
        logic [OW-1:0]    bias;
        logic [OW-1:0]    res;
    } vec_t;

    vec_t vt[5];

    initial begin
        int   lat;
        int   wr;
        logic ov;

        vt[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5},
                  16'd0, 16'h0046};
        vt[1] = '{'0, {16'd9, 16'd9, 16'd9, 16'd9}, 16'h1234, 16'h1234};
        vt[2] = '{{4{16'hFFFF}}, {4{16'hFFFF}}, 16'd0, 16'h0004};
        vt[3] = '{{16'd40, 16'd30, 16'd20, 16'd10}, {4{16'd1}},
                  16'd100, 16'd200};
        vt[4] = '{{16'd1, 16'd1, 16'd1, 16'd2}, {16'd3, 16'd3, 16'd3, 16'h8000},
                  16'hFFFF, 16'h0008};

        rst_n       = 1'b0;
        out_ready   = 1'b1;
        chain_en    = 1'b1;
        man_done    = 1'b0;
        man_sel     = 1'b0;
        man_partial = '0;
        in_valid    = 1'b1;
        in_data     = vt[0].data;
        in_weight   = vt[0].weight;
        in_bias     = vt[0].bias;

        // reset with a job already offered
        repeat (3) @(negedge clk);
        chk("reset ctl", {in_ready, pe_wr_en, pe_start, out_valid, busy,
                          timeout_err}, 0);
        chk("reset bus", {pe_data, pe_weight}, 0);
        chk("reset out", {pe_partial_in, out_result}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("no ready before edge", {in_ready, busy}, 2'b00);
        @(negedge clk);
        chk("ready after edge", {in_ready, busy}, 2'b10);
        exp_q.push_back(vt[0].res);
        @(negedge clk);
        chk("first accept", {busy, pe_wr_en, pe_start}, 3'b111);
        in_valid = 1'b0;
        wait_out(lat, wr);

        // vector table
        for (int i = 0; i < 5; i++) begin
            submit(vt[i].data, vt[i].weight, vt[i].bias, 1, vt[i].res);
            wait_out(lat, wr);
            chk("latency", lat, 6);
            chk("wr_en cycles", wr, 5);
            chk("pe bus latch", {pe_data, pe_weight}, {vt[i].data, vt[i].weight});
            chk("pe bias latch", pe_partial_in, vt[i].bias);
        end

        // backpressure on the result
        @(posedge clk);
        #1 out_ready = 1'b0;
        submit(vt[0].data, vt[0].weight, vt[0].bias, 1, vt[0].res);
        wait_out(lat, wr);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp hold", {out_valid, in_ready, pe_wr_en, pe_start, out_result},
                {1'b1, 1'b0, 1'b0, 1'b0, vt[0].res});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp release idle", {out_valid, busy, in_ready}, 3'b001);

        // watchdog abort
        chain_en = 1'b0;
        ov = 1'b0;
        submit(vt[1].data, vt[1].weight, vt[1].bias, 0, '0);
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            ov |= out_valid;
            if (c == 64) chk("to run64", {pe_wr_en, timeout_err}, 2'b10);
            if (c == 65) chk("to abort", {timeout_err, pe_wr_en, pe_start,
                                          in_ready, busy, out_valid}, 6'b100010);
            if (c == 66) chk("to idle", {timeout_err, in_ready, busy, out_valid},
                             4'b1100);
        end
        chk("abort no out_valid", ov, 0);
        chain_en = 1'b1;
        submit(vt[2].data, vt[2].weight, vt[2].bias, 1, vt[2].res);
        @(negedge clk);
        chk("err cleared", timeout_err, 0);
        wait_out(lat, wr);

        // done on the terminal-count cycle
        chain_en    = 1'b0;
        man_sel     = 1'b1;
        man_partial = 16'h1234;
        submit(vt[3].data, vt[3].weight, vt[3].bias, 1, 16'h1234);
        for (int c = 1; c <= 64; c++) @(negedge clk);
        man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        @(negedge clk);
        chk("tc result", {out_valid, timeout_err, out_result},
            {1'b1, 1'b0, 16'h1234});
        @(posedge clk);
        #1 man_sel = 1'b0;

        // reset in the middle of RUN
        chain_en = 1'b1;
        submit(vt[0].data, vt[0].weight, vt[0].bias, 0, '0);
        repeat (3) @(negedge clk);
        chk("mid run drive", {pe_wr_en, pe_start}, 2'b11);
        #1 rst_n = 1'b0;
        #1 chk("async drop", {pe_wr_en, pe_start, busy}, 3'b000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        ov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ov |= out_valid;
        end
        chk("late done ignored", ov, 0);
        chk("idle after reset", {busy, in_ready}, 2'b01);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
